adc_channel_scheduler: RTL and testbench

- Sequences the modular-ADC IP command/response stream.
- Issues atomic I/Q channel pairs for the SDR sample path.
- Shares the same ADC with one low-rate auxiliary requester (housekeeping: temperature, supply, RSSI).
- Tracks in-flight commands with a tag FIFO and routes each response to the I/Q sample output or the aux port.

---
 rtl/adc_sched_pkg.sv | 21 ++
 rtl/adc_tag_fifo.sv | 53 +++++
 rtl/adc_channel_scheduler.sv | 175 +++++++++++++++++
 tb/tb_adc_channel_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared types and widths for the ADC channel scheduler
package adc_sched_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;

    typedef enum logic [1:0] {
        TAG_I,
        TAG_Q,
        TAG_AUX
    } tag_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_I,
        S_CMD_Q,
        S_CMD_AUX,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/adc_tag_fifo.sv
// rtl/adc_tag_fifo.sv - in-order tag FIFO tracking outstanding ADC commands
module adc_tag_fifo
    import adc_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output tag_t pop_tag,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_tag = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/adc_channel_scheduler.sv
// rtl/adc_channel_scheduler.sv - I/Q pair + aux command scheduler for a shared ADC; ADC_SCHED_STATS_EN adds pair/aux counters
module adc_channel_scheduler
    import adc_sched_pkg::*;
#(
    parameter logic [ADC_CH_W-1:0] CHANNEL_I    = 5'd3,
    parameter logic [ADC_CH_W-1:0] CHANNEL_Q    = 5'd4,
    parameter int                  AUX_INTERVAL = 8,
    parameter int                  TAG_DEPTH    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    output logic                  o_cmd_valid,
    output logic [ADC_CH_W-1:0]   o_cmd_channel,
    output logic                  o_cmd_sop,
    output logic                  o_cmd_eop,
    input  logic                  i_cmd_ready,
    input  logic                  i_rsp_valid,
    input  logic [ADC_DATA_W-1:0] i_rsp_data,
    output logic                  o_sample_stb,
    output logic [ADC_DATA_W-1:0] o_sample_i,
    output logic [ADC_DATA_W-1:0] o_sample_q,
    input  logic                  i_aux_req,
    input  logic [ADC_CH_W-1:0]   i_aux_channel,
    output logic                  o_aux_ack,
    output logic [ADC_DATA_W-1:0] o_aux_data,
    output logic                  o_busy,
    output logic                  o_protocol_err
`ifdef ADC_SCHED_STATS_EN
    ,
    output logic [15:0]           o_pair_count,
    output logic [15:0]           o_aux_count
`endif
);

    localparam logic [7:0] AUX_C = 8'(AUX_INTERVAL);

    state_t                state;
    state_t                state_next;
    logic [7:0]            pair_cnt;
    logic [7:0]            pair_cnt_inc;
    logic                  aux_pending;
    logic                  aux_eligible;
    logic [ADC_CH_W-1:0]   aux_ch_q;
    logic                  sop_flag;
    logic [ADC_DATA_W-1:0] held_i;
    logic                  cmd_accept;
    logic                  fifo_full;
    logic                  fifo_empty;
    tag_t                  push_tag;
    tag_t                  head_tag;

    assign cmd_accept   = o_cmd_valid & i_cmd_ready;
    assign pair_cnt_inc = (pair_cnt == 8'hFF) ? pair_cnt : pair_cnt + 8'd1;
    assign aux_eligible = i_aux_req & ~aux_pending & (pair_cnt_inc >= AUX_C);
    assign o_cmd_sop    = sop_flag & o_cmd_valid;
    assign o_cmd_eop    = 1'b0;
    assign o_busy       = (state != S_IDLE) | ~fifo_empty;

    adc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .push     (cmd_accept),
        .push_tag (push_tag),
        .pop      (i_rsp_valid),
        .pop_tag  (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Accept is recomputed locally from fifo_full so the block does not read its own o_cmd_valid.
    always_comb begin
        state_next    = state;
        o_cmd_valid   = 1'b0;
        o_cmd_channel = '0;
        push_tag      = TAG_I;
        case (state)
            S_IDLE: begin
                if (i_enable) state_next = S_CMD_I;
            end
            S_CMD_I: begin
                o_cmd_valid   = ~fifo_full;
                o_cmd_channel = CHANNEL_I;
                push_tag      = TAG_I;
                if (~fifo_full & i_cmd_ready) state_next = S_CMD_Q;
            end
            S_CMD_Q: begin
                o_cmd_valid   = ~fifo_full;
                o_cmd_channel = CHANNEL_Q;
                push_tag      = TAG_Q;
                if (~fifo_full & i_cmd_ready) begin
                    if (!i_enable)         state_next = S_DRAIN;
                    else if (aux_eligible) state_next = S_CMD_AUX;
                    else                   state_next = S_CMD_I;
                end
            end
            S_CMD_AUX: begin
                o_cmd_valid   = ~fifo_full;
                o_cmd_channel = aux_ch_q;
                push_tag      = TAG_AUX;
                if (~fifo_full & i_cmd_ready) state_next = i_enable ? S_CMD_I : S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty & ~i_rsp_valid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= S_IDLE;
            pair_cnt       <= AUX_C;
            aux_pending    <= 1'b0;
            aux_ch_q       <= '0;
            sop_flag       <= 1'b0;
            held_i         <= '0;
            o_sample_stb   <= 1'b0;
            o_sample_i     <= '0;
            o_sample_q     <= '0;
            o_aux_ack      <= 1'b0;
            o_aux_data     <= '0;
            o_protocol_err <= 1'b0;
        end else begin
            state        <= state_next;
            o_sample_stb <= 1'b0;
            o_aux_ack    <= 1'b0;

            if (state == S_IDLE && i_enable) sop_flag <= 1'b1;
            else if (cmd_accept)             sop_flag <= 1'b0;

            if (cmd_accept && state == S_CMD_Q)   pair_cnt <= pair_cnt_inc;
            if (cmd_accept && state == S_CMD_AUX) pair_cnt <= '0;

            // Channel is captured once so the command stays stable even if the requester changes it.
            if (state == S_CMD_Q && state_next == S_CMD_AUX) aux_ch_q <= i_aux_channel;

            if (i_rsp_valid) begin
                if (fifo_empty) begin
                    o_protocol_err <= 1'b1;
                end else begin
                    case (head_tag)
                        TAG_I: held_i <= i_rsp_data;
                        TAG_Q: begin
                            o_sample_i   <= held_i;
                            o_sample_q   <= i_rsp_data;
                            o_sample_stb <= 1'b1;
                        end
                        TAG_AUX: begin
                            o_aux_data  <= i_rsp_data;
                            o_aux_ack   <= 1'b1;
                            aux_pending <= 1'b0;
                        end
                        default: held_i <= held_i;
                    endcase
                end
            end

            if (cmd_accept && state == S_CMD_AUX) aux_pending <= 1'b1;
        end
    end

`ifdef ADC_SCHED_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pair_count <= '0;
            o_aux_count  <= '0;
        end else begin
            if (o_sample_stb) o_pair_count <= o_pair_count + 16'd1;
            if (o_aux_ack)    o_aux_count  <= o_aux_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// tb/tb_adc_channel_scheduler.sv - directed self-checking bench for adc_channel_scheduler
module tb_adc_channel_scheduler;
    import adc_sched_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        o_cmd_valid;
    logic [4:0]  o_cmd_channel;
    logic        o_cmd_sop;
    logic        o_cmd_eop;
    logic        i_cmd_ready = 1'b0;
    logic        i_rsp_valid = 1'b0;
    logic [11:0] i_rsp_data = '0;
    logic        o_sample_stb;
    logic [11:0] o_sample_i;
    logic [11:0] o_sample_q;
    logic        i_aux_req = 1'b0;
    logic [4:0]  i_aux_channel = '0;
    logic        o_aux_ack;
    logic [11:0] o_aux_data;
    logic        o_busy;
    logic        o_protocol_err;
`ifdef ADC_SCHED_STATS_EN
    logic [15:0] o_pair_count;
    logic [15:0] o_aux_count;
`endif

    adc_channel_scheduler dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .o_cmd_valid    (o_cmd_valid),
        .o_cmd_channel  (o_cmd_channel),
        .o_cmd_sop      (o_cmd_sop),
        .o_cmd_eop      (o_cmd_eop),
        .i_cmd_ready    (i_cmd_ready),
        .i_rsp_valid    (i_rsp_valid),
        .i_rsp_data     (i_rsp_data),
        .o_sample_stb   (o_sample_stb),
        .o_sample_i     (o_sample_i),
        .o_sample_q     (o_sample_q),
        .i_aux_req      (i_aux_req),
        .i_aux_channel  (i_aux_channel),
        .o_aux_ack      (o_aux_ack),
        .o_aux_data     (o_aux_data),
        .o_busy         (o_busy),
        .o_protocol_err (o_protocol_err)
`ifdef ADC_SCHED_STATS_EN
        ,
        .o_pair_count   (o_pair_count),
        .o_aux_count    (o_aux_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    int          cyc    = 0;
    bit          auto_rsp = 1'b0;
    bit          sched_v [16];
    logic [11:0] sched_d [16];
    logic [4:0]  acc_ch [$];
    bit          acc_sop [$];
    logic [23:0] samples [$];
    logic [11:0] aux_acks [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] adc_value(input logic [4:0] ch);
        case (ch)
            5'd3:    return 12'h123;
            5'd4:    return 12'h456;
            default: return 12'hABC;
        endcase
    endfunction

    // Called at a falling edge: logs what the DUT shows now, then advances one cycle.
    task automatic tick();
        if (!i_reset && o_cmd_valid === 1'b1 && i_cmd_ready) begin
            acc_ch.push_back(o_cmd_channel);
            acc_sop.push_back(o_cmd_sop);
            if (auto_rsp) begin
                sched_v[(cyc + 2) % 16] = 1'b1;
                sched_d[(cyc + 2) % 16] = adc_value(o_cmd_channel);
            end
        end
        if (o_sample_stb === 1'b1) samples.push_back({o_sample_i, o_sample_q});
        if (o_aux_ack === 1'b1) begin
            aux_acks.push_back(o_aux_data);
            i_aux_req = 1'b0;
        end
        @(negedge i_clk);
        cyc++;
        if (auto_rsp) begin
            i_rsp_valid = sched_v[cyc % 16];
            i_rsp_data  = sched_d[cyc % 16];
            sched_v[cyc % 16] = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_rsp_valid = 1'b0;
        for (int k = 0; k < 16; k++) sched_v[k] = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        acc_ch.delete();
        acc_sop.delete();
        samples.delete();
        aux_acks.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        int bad;
        int nsop;
        int n17;

        @(negedge i_clk);
        do_reset();

        // Reset state
        check("rst_cmd_valid", o_cmd_valid, 0);
        check("rst_cmd_channel", o_cmd_channel, 0);
        check("rst_cmd_sop", o_cmd_sop, 0);
        check("rst_cmd_eop", o_cmd_eop, 0);
        check("rst_sample_stb", o_sample_stb, 0);
        check("rst_aux_ack", o_aux_ack, 0);
        check("rst_busy", o_busy, 0);
        check("rst_protocol_err", o_protocol_err, 0);
        repeat (3) tick();
        check("idle_no_enable_busy", o_busy, 0);

        // Continuous I/Q sampling
        auto_rsp = 1'b1; i_enable = 1'b1; i_cmd_ready = 1'b1;
        repeat (20) tick();
        check("t1_accept_count_ge8", acc_ch.size() >= 8, 1);
        bad = 0;
        foreach (acc_ch[k]) if (acc_ch[k] !== ((k % 2 == 0) ? 5'd3 : 5'd4)) bad++;
        check("t1_channel_alternation", bad, 0);
        check("t1_first_ch", acc_ch[0], 3);
        check("t1_second_ch", acc_ch[1], 4);
        nsop = 0;
        foreach (acc_sop[k]) if (acc_sop[k]) nsop++;
        check("t1_sop_count", nsop, 1);
        check("t1_sop_first", acc_sop[0], 1);
        check("t1_sample_count_ge4", samples.size() >= 4, 1);
        bad = 0;
        foreach (samples[k]) if (samples[k] !== 24'h123456) bad++;
        check("t1_sample_data", bad, 0);
        check("t1_busy", o_busy, 1);
        check("t1_no_err", o_protocol_err, 0);

        // Aux insertion and re-request spacing
        i_aux_req = 1'b1; i_aux_channel = 5'd17;
        do_reset();
        guard = 0;
        while (aux_acks.size() == 0 && guard < 40) begin tick(); guard++; end
        check("t2_first_ack_seen", aux_acks.size(), 1);
        tick();
        i_aux_req = 1'b1;
        repeat (40) tick();
        check("t2_accept_count_ge20", acc_ch.size() >= 20, 1);
        check("t2_after_pair1_ch", acc_ch[2], 17);
        check("t2_after_pair9_ch", acc_ch[19], 17);
        n17 = 0;
        foreach (acc_ch[k]) if (acc_ch[k] === 5'd17) n17++;
        check("t2_aux_cmd_count", n17, 2);
        check("t2_ack_count", aux_acks.size(), 2);
        check("t2_ack_data0", aux_acks[0], 12'hABC);
        check("t2_ack_data1", aux_acks[1], 12'hABC);
        bad = 0;
        foreach (samples[k]) if (samples[k] !== 24'h123456) bad++;
        check("t2_sample_data", bad, 0);

        // Backpressure on Q: command held, no aux mid-pair
        i_aux_req = 1'b1; i_aux_channel = 5'd17;
        do_reset();
        guard = 0;
        while (!(o_cmd_valid === 1'b1 && o_cmd_channel === 5'd3) && guard < 20) begin tick(); guard++; end
        tick();
        i_cmd_ready = 1'b0;
        bad = 0;
        repeat (10) begin
            if (o_cmd_valid !== 1'b1 || o_cmd_channel !== 5'd4) bad++;
            tick();
        end
        check("t3_q_held_stable", bad, 0);
        check("t3_q_valid", o_cmd_valid, 1);
        check("t3_q_channel", o_cmd_channel, 4);
        i_cmd_ready = 1'b1;
        tick();
        tick();
        check("t3_accept_count", acc_ch.size(), 3);
        check("t3_pair_q", acc_ch[1], 4);
        check("t3_aux_after_pair", acc_ch[2], 17);

        // Tag FIFO full: responses withheld
        i_aux_req = 1'b0; auto_rsp = 1'b0;
        do_reset();
        repeat (10) tick();
        check("t4_accepts_at_full", acc_ch.size(), 4);
        check("t4_valid_low_full", o_cmd_valid, 0);
        check("t4_busy_full", o_busy, 1);
        i_rsp_valid = 1'b1; i_rsp_data = 12'h111;
        tick();
        i_rsp_valid = 1'b0;
        check("t4_valid_after_pop", o_cmd_valid, 1);
        check("t4_channel_after_pop", o_cmd_channel, 3);
        check("t4_no_stb_on_i", o_sample_stb, 0);
        i_rsp_valid = 1'b1; i_rsp_data = 12'h222;
        tick();
        i_rsp_valid = 1'b0;
        check("t4_stb_latency1", o_sample_stb, 1);
        check("t4_sample_i", o_sample_i, 12'h111);
        check("t4_sample_q", o_sample_q, 12'h222);
        check("t4_push_pop_not_full", o_cmd_valid, 1);
        check("t4_accepts_push_pop", acc_ch.size(), 5);
        tick();
        check("t4_stb_pulse", o_sample_stb, 0);
        check("t4_full_again", o_cmd_valid, 0);
        check("t4_accepts_final", acc_ch.size(), 6);

        // Enable drop during I accept, drain, re-enable
        auto_rsp = 1'b1;
        do_reset();
        guard = 0;
        while (!(o_cmd_valid === 1'b1 && o_cmd_channel === 5'd3) && guard < 20) begin tick(); guard++; end
        i_enable = 1'b0;
        tick();
        check("t5_q_still_valid", o_cmd_valid, 1);
        check("t5_q_channel", o_cmd_channel, 4);
        tick();
        check("t5_drain_valid_low", o_cmd_valid, 0);
        check("t5_drain_busy", o_busy, 1);
        guard = 0;
        while (o_busy === 1'b1 && guard < 10) begin tick(); guard++; end
        check("t5_busy_falls", o_busy, 0);
        check("t5_accept_count", acc_ch.size(), 2);
        check("t5_sample_count", samples.size(), 1);
        check("t5_sample_data", samples[0], 24'h123456);
        i_enable = 1'b1;
        guard = 0;
        while (o_cmd_valid !== 1'b1 && guard < 10) begin tick(); guard++; end
        check("t5_reenable_sop", o_cmd_sop, 1);
        check("t5_reenable_channel", o_cmd_channel, 3);

        // Reset mid-flight, then stray response
        i_enable = 1'b0; auto_rsp = 1'b0;
        do_reset();
        check("t6_err_clear_after_reset", o_protocol_err, 0);
        check("t6_busy_after_reset", o_busy, 0);
        i_rsp_valid = 1'b1; i_rsp_data = 12'h555;
        tick();
        i_rsp_valid = 1'b0;
        check("t6_err_set", o_protocol_err, 1);
        check("t6_no_stb", o_sample_stb, 0);
        check("t6_no_ack", o_aux_ack, 0);
        repeat (3) tick();
        check("t6_err_sticky", o_protocol_err, 1);
        check("t6_idle_busy", o_busy, 0);
        do_reset();
        check("t6_err_cleared_by_reset", o_protocol_err, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
